// File: rtl/ddr2_arb_pkg.sv
// Shared types for the DDR2 read/write arbiter: FSM states, side encoding, defaults.
package ddr2_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  localparam logic SIDE_WR = 1'b1;
  localparam logic SIDE_RD = 1'b0;

  localparam int BURST_LEN_DEF = 8;

endpackage

// File: rtl/ddr2_arb_watchdog.sv
// Completion watchdog: starts on command accept, expires DONE_TIMEOUT cycles later
// unless cleared by the arbiter first.
module ddr2_arb_watchdog #(
  parameter int DONE_TIMEOUT = 1023
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic clear_i,
  output logic expire_o
);

  localparam int CW = $clog2(DONE_TIMEOUT + 1);

  logic          run_q, run_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q equals the number of full cycles already spent waiting
  assign expire_o = run_q && (cnt_q == CW'(DONE_TIMEOUT - 1));

  always_comb begin
    run_d = run_q;
    cnt_d = cnt_q;
    if (start_i) begin
      run_d = 1'b1;
      cnt_d = '0;
    end else if (clear_i || expire_o) begin
      run_d = 1'b0;
      cnt_d = '0;
    end else if (run_q) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ddr2_rw_arbiter.sv
// Shares the DDR2 controller command port between a write and a read requester.
// Round-robin by default; define DDR2_ARB_WR_PRIO_EN for write-priority arbitration.
module ddr2_rw_arbiter
  import ddr2_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 26,
  parameter int BURST_LEN    = BURST_LEN_DEF,
  parameter int STARVE_LIMIT = 4,
  parameter int DONE_TIMEOUT = 1023
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  init_end,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_ack,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ack,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic                  cmd_wr,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [7:0]            cmd_len,
  input  logic                  cmd_done,
  output logic                  arb_busy,
  output logic                  arb_err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_e            state_q, state_d;
  logic                  last_q, last_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic                  cmd_wr_q, cmd_wr_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [7:0]            cmd_len_q, cmd_len_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  rd_ack_q, rd_ack_d;
  logic                  err_q, err_d;

  logic wd_start, wd_clear, wd_expire;
  logic both, starved, pref, pick, other_req;

  ddr2_arb_watchdog #(
    .DONE_TIMEOUT(DONE_TIMEOUT)
  ) u_wdog (
    .clk_i    (sys_clk),
    .rst_ni   (sys_rst_n),
    .start_i  (wd_start),
    .clear_i  (wd_clear),
    .expire_o (wd_expire)
  );

  // starve_q counts repeat grants, so STARVE_LIMIT-1 repeats means STARVE_LIMIT in a row
  always_comb begin
    both    = wr_req & rd_req;
    starved = (starve_q == SW'(STARVE_LIMIT - 1));
`ifdef DDR2_ARB_WR_PRIO_EN
    pref    = SIDE_WR;
`else
    pref    = ~last_q;
`endif
    if (!both)        pick = wr_req ? SIDE_WR : SIDE_RD;
    else if (starved) pick = ~last_q;
    else              pick = pref;
    other_req = (pick == SIDE_WR) ? rd_req : wr_req;
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    starve_d    = starve_q;
    cmd_valid_d = cmd_valid_q;
    cmd_wr_d    = cmd_wr_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_len_d   = cmd_len_q;
    wr_ack_d    = 1'b0;
    rd_ack_d    = 1'b0;
    err_d       = err_q;
    wd_start    = 1'b0;
    wd_clear    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (init_end && (wr_req || rd_req)) begin
          state_d     = ST_ISSUE;
          cmd_valid_d = 1'b1;
          cmd_wr_d    = pick;
          cmd_addr_d  = (pick == SIDE_WR) ? wr_addr : rd_addr;
          cmd_len_d   = 8'(BURST_LEN);
          if ((pick == last_q) && other_req)
            starve_d = (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + SW'(1);
          else
            starve_d = '0;
        end
      end
      ST_ISSUE: begin
        if (cmd_ready) begin
          state_d     = ST_WAIT;
          cmd_valid_d = 1'b0;
          wr_ack_d    = cmd_wr_q;
          rd_ack_d    = ~cmd_wr_q;
          last_d      = cmd_wr_q;
          wd_start    = 1'b1;
        end
      end
      ST_WAIT: begin
        // a done on the expiry cycle still counts as a clean completion
        if (cmd_done) begin
          state_d  = ST_IDLE;
          wd_clear = 1'b1;
        end else if (wd_expire) begin
          state_d  = ST_IDLE;
          err_d    = 1'b1;
          wd_clear = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      last_q      <= SIDE_RD;
      starve_q    <= '0;
      cmd_valid_q <= 1'b0;
      cmd_wr_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_len_q   <= '0;
      wr_ack_q    <= 1'b0;
      rd_ack_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      starve_q    <= starve_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_len_q   <= cmd_len_d;
      wr_ack_q    <= wr_ack_d;
      rd_ack_q    <= rd_ack_d;
      err_q       <= err_d;
    end
  end

  assign wr_ack    = wr_ack_q;
  assign rd_ack    = rd_ack_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_wr    = cmd_wr_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_len   = cmd_len_q;
  assign arb_busy  = (state_q != ST_IDLE);
  assign arb_err   = err_q;

endmodule

// File: tb/tb_ddr2_rw_arbiter.sv
// Directed bench for ddr2_rw_arbiter; expected grant order follows DDR2_ARB_WR_PRIO_EN.
module tb_ddr2_rw_arbiter;

  localparam int AW = 26;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n, init_end, wr_req, rd_req, cmd_ready, cmd_done;
  logic [AW-1:0] wr_addr, rd_addr;
  logic          wr_ack, rd_ack, cmd_valid, cmd_wr, arb_busy, arb_err;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;

  int errors = 0;
  int checks = 0;

  always #5 sys_clk = ~sys_clk;

  ddr2_rw_arbiter #(.ADDR_WIDTH(AW)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .init_end  (init_end),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_ack    (wr_ack),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_ack    (rd_ack),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_wr    (cmd_wr),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_done  (cmd_done),
    .arb_busy  (arb_busy),
    .arb_err   (arb_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_ack(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      tick();
      if (wr_ack || rd_ack) ok = 1'b1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, cmd_valid, 0);
    chk({tag, "_acks"},  {wr_ack, rd_ack}, 0);
    chk({tag, "_wr"},    cmd_wr, 0);
    chk({tag, "_addr"},  cmd_addr, 0);
    chk({tag, "_len"},   cmd_len, 0);
    chk({tag, "_busy"},  arb_busy, 0);
    chk({tag, "_err"},   arb_err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    bit ok, side, found;
    int n;
    logic exp_side;

    // reset with a pending write but no init_end
    sys_rst_n = 1'b0; init_end = 1'b0; wr_req = 1'b1; rd_req = 1'b0;
    wr_addr = 26'h123456; rd_addr = 26'h2ABCDEF; cmd_ready = 1'b0; cmd_done = 1'b0;
    #3;
    chk_all_zero("rst");
    tick(); tick();
    sys_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_no_grant_pre_init", {cmd_valid, arb_busy}, 0);
    end
    init_end = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 2 && !found; i++) begin
      tick();
      if (cmd_valid) found = 1'b1;
    end
    chk("t1_valid_in_2", found, 1);
    chk("t1_cmd_wr", cmd_wr, 1);
    chk("t1_cmd_addr", cmd_addr, 26'h123456);
    chk("t1_cmd_len", cmd_len, 8);

    // controller stalls: command fields must hold, no ack
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_hold_valid", cmd_valid, 1);
      chk("t4_hold_fields", {cmd_wr, cmd_addr}, {1'b1, 26'h123456});
      chk("t4_no_ack", {wr_ack, rd_ack}, 0);
    end
    cmd_ready = 1'b1;
    tick();
    chk("t4_ack_on_accept", {wr_ack, rd_ack}, 2'b10);
    chk("t4_valid_drop", cmd_valid, 0);
    wr_req = 1'b0;
    tick();
    chk("t4_ack_single", {wr_ack, rd_ack}, 0);
    chk("t4_busy_wait", arb_busy, 1);

    // no cmd_done: timeout lands 1023 cycles after the accept edge
    n = 1;
    while (!arb_err && n < 1100) begin
      tick();
      n++;
    end
    chk("t5_err_latency", n, 1023);
    chk("t5_busy_after_to", arb_busy, 0);
    rd_req = 1'b1;
    wait_ack(10, ok);
    chk("t5_next_granted", ok, 1);
    chk("t5_rd_ack", {wr_ack, rd_ack}, 2'b01);
    chk("t5_rd_fields", {cmd_wr, cmd_addr}, {1'b0, 26'h2ABCDEF});
    chk("t5_err_sticky", arb_err, 1);
    rd_req = 1'b0;

    // async reset mid WAIT_DONE, checked before any clock edge
    #2;
    chk("t6_busy_pre", arb_busy, 1);
    sys_rst_n = 1'b0;
    #1;
    chk_all_zero("t6");

    // both requesters always pending, done 5 cycles after each accept
    wr_req = 1'b1; rd_req = 1'b1; cmd_ready = 1'b1;
    wr_addr = 26'h0000ABC; rd_addr = 26'h3000001;
    tick();
    sys_rst_n = 1'b1;
    for (int g = 0; g < 10; g++) begin
      wait_ack(12, ok);
      chk("t2_ack_seen", ok, 1);
      if (!ok) break;
      chk("t2_not_both", wr_ack & rd_ack, 0);
      side = wr_ack;
`ifdef DDR2_ARB_WR_PRIO_EN
      exp_side = (g % 5 == 4) ? 1'b0 : 1'b1;
`else
      exp_side = (g % 2 == 0) ? 1'b1 : 1'b0;
`endif
      chk("t2_order", side, exp_side);
      chk("t2_cmd_wr", cmd_wr, side);
      chk("t2_cmd_addr", cmd_addr, side ? 26'h0000ABC : 26'h3000001);
      tick();
      chk("t2_ack_pulse", {wr_ack, rd_ack}, 0);
      repeat (3) tick();
      cmd_done = 1'b1;
      tick();
      cmd_done = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
